ad_frame_tracker: RTL and testbench

Tracks the external frame-sync and sample-clock pair (IN_SYNC / IN_SPCLK, 200 kHz) in the ADC fast-clock domain and produces the per-sample write-start strobe and frame bookkeeping consumed by `ad_cache`. It sits directly upstream of `ad_cache` and `AD7960`, replacing the raw sync/spclk wiring. It synchronises the asynchronous inputs and locks onto frame boundaries. It flywheels through a bounded number of missing sync pulses and flags malformed frames.

---
 rtl/ad_frame_tracker.sv | 198 +++++++++++++++++++
 tb/tb_ad_frame_tracker.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_frame_tracker.sv
// ---------------------------------------------------------------------------
// ad_frame_tracker
//   Locks onto the external frame-sync / sample-clock pair in the ADC fast
//   clock domain. It produces one write-start strobe per accepted sample, and
//   it keeps the sample index, frame count, flywheel count and sticky error
//   flags for the downstream sample cache.
//
// Ports
//   clk           in   ADC fast clock
//   rst_n         in   asynchronous active-low reset
//   en            in   acquisition enable (clk domain)
//   sync_i        in   raw frame sync (asynchronous)
//   spclk_i       in   raw sample clock (asynchronous)
//   start_o       out  one-cycle strobe per accepted sample while locked
//   sop_o         out  strobe coincident with start_o for sample index 0
//   sample_idx_o  out  index of the sample strobed by start_o
//   frame_cnt_o   out  frames started since lock (wraps)
//   locked_o      out  high while tracking frames
//   miss_cnt_o    out  consecutive flywheeled boundaries (saturating)
//   err_o         out  sticky {timeout, long, short}, cleared while en=0
// ---------------------------------------------------------------------------
module ad_frame_tracker #(
    parameter int unsigned SP_PER_FRAME = 512,
    parameter int unsigned IDX_NBIT     = 9,
    parameter int unsigned MISS_MAX     = 8,
    parameter int unsigned TIMEOUT      = 3000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                sync_i,
    input  logic                spclk_i,
    output logic                start_o,
    output logic                sop_o,
    output logic [IDX_NBIT-1:0] sample_idx_o,
    output logic [15:0]         frame_cnt_o,
    output logic                locked_o,
    output logic [3:0]          miss_cnt_o,
    output logic [2:0]          err_o
);

    localparam int unsigned WD_NBIT = $clog2(TIMEOUT + 1);
    localparam int unsigned N_NBIT  = IDX_NBIT + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HUNT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Input path registers
    logic [1:0]          r_sync_ff;
    logic [1:0]          r_spclk_ff;
    logic                r_spclk_prev;
    logic                r_edge;
    logic                r_edge_sync;

    // Tracker state
    state_t              r_state;
    logic                r_start;
    logic                r_sop;
    logic [IDX_NBIT-1:0] r_idx;
    logic [15:0]         r_frame;
    logic                r_locked;
    logic [3:0]          r_miss;
    logic [2:0]          r_err;
    logic [WD_NBIT-1:0]  r_wd;

    logic [N_NBIT-1:0]   w_n;
    logic                w_frame_end;
    logic [3:0]          w_miss_inc;

    // Next sample index, computed one bit wider so SP_PER_FRAME is representable
    assign w_n         = N_NBIT'(r_idx) + N_NBIT'(1);
    assign w_frame_end = (w_n == N_NBIT'(SP_PER_FRAME));
    assign w_miss_inc  = (r_miss == 4'hF) ? r_miss : r_miss + 4'd1;

    // Two-stage synchronisers, then a registered rising-edge detect.
    // The sync level is captured alongside the edge so both refer to the
    // same input sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_ff    <= 2'b00;
            r_spclk_ff   <= 2'b00;
            r_spclk_prev <= 1'b0;
            r_edge       <= 1'b0;
            r_edge_sync  <= 1'b0;
        end else begin
            r_sync_ff    <= {r_sync_ff[0], sync_i};
            r_spclk_ff   <= {r_spclk_ff[0], spclk_i};
            r_spclk_prev <= r_spclk_ff[1];
            r_edge       <= r_spclk_ff[1] & ~r_spclk_prev;
            r_edge_sync  <= r_sync_ff[1];
        end
    end

    // Frame tracking FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_start  <= 1'b0;
            r_sop    <= 1'b0;
            r_idx    <= '0;
            r_frame  <= '0;
            r_locked <= 1'b0;
            r_miss   <= '0;
            r_err    <= '0;
            r_wd     <= '0;
        end else begin
            r_start <= 1'b0;
            r_sop   <= 1'b0;
            if (!en) begin
                // Disable wins over any strobe that was due this cycle
                r_state  <= ST_IDLE;
                r_idx    <= '0;
                r_frame  <= '0;
                r_locked <= 1'b0;
                r_miss   <= '0;
                r_err    <= '0;
                r_wd     <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_HUNT;
                    end

                    ST_HUNT: begin
                        if (r_edge && r_edge_sync) begin
                            r_state  <= ST_RUN;
                            r_start  <= 1'b1;
                            r_sop    <= 1'b1;
                            r_idx    <= '0;
                            r_frame  <= '0;
                            r_miss   <= '0;
                            r_locked <= 1'b1;
                            r_wd     <= '0;
                        end
                    end

                    ST_RUN: begin
                        if (r_edge) begin
                            r_wd <= '0;
                            if (r_edge_sync) begin
                                // Sync always restarts the frame; early sync is flagged
                                if (!w_frame_end) begin
                                    r_err[0] <= 1'b1;
                                end
                                r_start <= 1'b1;
                                r_sop   <= 1'b1;
                                r_idx   <= '0;
                                r_frame <= r_frame + 16'd1;
                                r_miss  <= '0;
                            end else if (w_frame_end) begin
                                if (r_miss == 4'(MISS_MAX)) begin
                                    // Too many boundaries without sync: give up the lock
                                    r_err[1] <= 1'b1;
                                    r_state  <= ST_HUNT;
                                    r_locked <= 1'b0;
                                end else begin
                                    // Flywheel: take the boundary on count alone
                                    r_start <= 1'b1;
                                    r_sop   <= 1'b1;
                                    r_idx   <= '0;
                                    r_frame <= r_frame + 16'd1;
                                    r_miss  <= w_miss_inc;
                                end
                            end else begin
                                r_start <= 1'b1;
                                r_idx   <= w_n[IDX_NBIT-1:0];
                            end
                        end else if (r_wd == WD_NBIT'(TIMEOUT - 1)) begin
                            // Watchdog reaches TIMEOUT on this cycle
                            r_wd     <= WD_NBIT'(TIMEOUT);
                            r_err[2] <= 1'b1;
                            r_state  <= ST_HUNT;
                            r_locked <= 1'b0;
                        end else if (r_wd != WD_NBIT'(TIMEOUT)) begin
                            r_wd <= r_wd + WD_NBIT'(1);
                        end
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign start_o      = r_start;
    assign sop_o        = r_sop;
    assign sample_idx_o = r_idx;
    assign frame_cnt_o  = r_frame;
    assign locked_o     = r_locked;
    assign miss_cnt_o   = r_miss;
    assign err_o        = r_err;

endmodule

// File: tb/tb_ad_frame_tracker.sv
// ---------------------------------------------------------------------------
// Testbench for ad_frame_tracker: directed vector table, hand-written corner
// sequences and a randomized run, all cross-checked every cycle against an
// event-level reference model.
// ---------------------------------------------------------------------------
module tb_ad_frame_tracker;

    localparam int SPF     = 16;
    localparam int IDXW    = 4;
    localparam int MISSMAX = 8;
    localparam int TOUT    = 100;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic            sync_i;
    logic            spclk_i;
    logic            start_o;
    logic            sop_o;
    logic [IDXW-1:0] sample_idx_o;
    logic [15:0]     frame_cnt_o;
    logic            locked_o;
    logic [3:0]      miss_cnt_o;
    logic [2:0]      err_o;

    ad_frame_tracker #(
        .SP_PER_FRAME (SPF),
        .IDX_NBIT     (IDXW),
        .MISS_MAX     (MISSMAX),
        .TIMEOUT      (TOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .sync_i       (sync_i),
        .spclk_i      (spclk_i),
        .start_o      (start_o),
        .sop_o        (sop_o),
        .sample_idx_o (sample_idx_o),
        .frame_cnt_o  (frame_cnt_o),
        .locked_o     (locked_o),
        .miss_cnt_o   (miss_cnt_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, exp);
        end
    endtask

    function automatic logic [29:0] pack_dut();
        return {locked_o, err_o, miss_cnt_o, frame_cnt_o, sample_idx_o, sop_o, start_o};
    endfunction

    // ------------------------------------------------------------------
    // Reference model: works on sample events. A rising spclk seen at a
    // clk edge becomes a sample event 3 cycles later, carrying the sync
    // level seen at the same edge.
    // ------------------------------------------------------------------
    typedef struct {
        int   due;
        logic s;
    } ev_t;

    localparam int M_IDLE = 0;
    localparam int M_HUNT = 1;
    localparam int M_RUN  = 2;

    ev_t  evq[$];
    int   cyc = 0;
    logic prev_sp = 1'b0;
    int   m_state = M_IDLE;
    logic m_start, m_sop, m_lk;
    int   m_idx, m_frame, m_miss, m_err, m_last;

    task automatic model_clear();
        m_state = M_IDLE;
        m_start = 1'b0; m_sop = 1'b0; m_lk = 1'b0;
        m_idx = 0; m_frame = 0; m_miss = 0; m_err = 0; m_last = 0;
    endtask

    task automatic model_boundary();
        m_start = 1'b1; m_sop = 1'b1; m_idx = 0;
        m_frame = (m_frame + 1) % 65536;
    endtask

    initial begin
        ev_t        e;
        logic       edge_now;
        logic       es;
        logic [29:0] exp_v;
        model_clear();
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                model_clear();
                evq.delete();
                prev_sp = 1'b0;
            end else begin
                cyc++;
                if (spclk_i && !prev_sp) begin
                    e.due = cyc + 3;
                    e.s   = sync_i;
                    evq.push_back(e);
                end
                prev_sp  = spclk_i;
                edge_now = 1'b0;
                es       = 1'b0;
                if (evq.size() > 0 && evq[0].due == cyc) begin
                    edge_now = 1'b1;
                    es       = evq[0].s;
                    void'(evq.pop_front());
                end
                m_start = 1'b0;
                m_sop   = 1'b0;
                if (!en) begin
                    model_clear();
                end else if (m_state == M_IDLE) begin
                    m_state = M_HUNT;
                end else if (m_state == M_HUNT) begin
                    if (edge_now && es) begin
                        m_state = M_RUN; m_lk = 1'b1;
                        m_start = 1'b1; m_sop = 1'b1;
                        m_idx = 0; m_frame = 0; m_miss = 0; m_last = cyc;
                    end
                end else begin
                    if (edge_now) begin
                        m_last = cyc;
                        if (es) begin
                            if (m_idx + 1 < SPF) m_err = m_err | 1;
                            model_boundary();
                            m_miss = 0;
                        end else if (m_idx + 1 == SPF) begin
                            if (m_miss == MISSMAX) begin
                                m_err = m_err | 2; m_state = M_HUNT; m_lk = 1'b0;
                            end else begin
                                model_boundary();
                                m_miss = (m_miss == 15) ? 15 : m_miss + 1;
                            end
                        end else begin
                            m_start = 1'b1;
                            m_idx   = m_idx + 1;
                        end
                    end else if (cyc - m_last == TOUT) begin
                        m_err = m_err | 4; m_state = M_HUNT; m_lk = 1'b0;
                    end
                end
            end
            exp_v = {m_lk, 3'(m_err), 4'(m_miss), 16'(m_frame), 4'(m_idx), m_sop, m_start};
            chk($sformatf("model cyc %0d", cyc), 32'(pack_dut()), 32'(exp_v));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    logic            g_start, g_sop, g_lk;
    logic [IDXW-1:0] g_idx;
    logic [15:0]     g_frame;
    logic [3:0]      g_miss;
    logic [2:0]      g_err;

    // One spclk period; outputs captured on the cycle its strobe is due
    task automatic do_pulse_chk(input logic s);
        @(negedge clk); sync_i = s;
        repeat (3) @(negedge clk);
        spclk_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        g_start = start_o; g_sop = sop_o; g_idx = sample_idx_o; g_frame = frame_cnt_o;
        g_miss = miss_cnt_o; g_err = err_o; g_lk = locked_o;
        @(negedge clk); spclk_i = 1'b0;
    endtask

    task automatic do_pulse(input logic s, input int lo, input int hi);
        @(negedge clk); sync_i = s;
        repeat (lo - 1) @(negedge clk);
        spclk_i = 1'b1;
        repeat (hi) @(negedge clk);
        spclk_i = 1'b0;
    endtask

    typedef struct {
        logic s;
        logic st;
        logic sop;
        int   idx;
        int   frame;
        int   miss;
        int   err;
        logic lk;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #1_000_000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n_sop;
        int max_miss;
        int cnt;
        int ph;
        int r;
        logic s;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0};  // sync-less edge in HUNT ignored
        tbl[1] = '{1'b1, 1'b1, 1'b1, 0, 0, 0, 0, 1'b1};  // lock
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1, 0, 0, 0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 2, 0, 0, 0, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 0, 1, 0, 1, 1'b1};  // short frame at idx 3
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1, 1, 0, 1, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 2, 1, 0, 1, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 3, 1, 0, 1, 1'b1};

        rst_n = 1'b0; en = 1'b0; sync_i = 1'b0; spclk_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset state", 32'(pack_dut()), 32'd0);

        @(negedge clk); en = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            do_pulse_chk(tbl[i].s);
            chk($sformatf("vec%0d start", i), 32'(g_start), 32'(tbl[i].st));
            chk($sformatf("vec%0d sop", i),   32'(g_sop),   32'(tbl[i].sop));
            chk($sformatf("vec%0d idx", i),   32'(g_idx),   32'(tbl[i].idx));
            chk($sformatf("vec%0d frame", i), 32'(g_frame), 32'(tbl[i].frame));
            chk($sformatf("vec%0d miss", i),  32'(g_miss),  32'(tbl[i].miss));
            chk($sformatf("vec%0d err", i),   32'(g_err),   32'(tbl[i].err));
            chk($sformatf("vec%0d locked", i), 32'(g_lk),   32'(tbl[i].lk));
        end

        // Run to the end of the frame, then a normal synced boundary
        repeat (12) do_pulse_chk(1'b0);
        chk("last idx", 32'(g_idx), 32'(SPF - 1));
        do_pulse_chk(1'b1);
        chk("normal sop", 32'(g_sop), 32'd1);
        chk("normal idx", 32'(g_idx), 32'd0);
        chk("normal frame", 32'(g_frame), 32'd2);
        chk("normal err", 32'(g_err), 32'd1);

        // Sync removed: MISS_MAX flywheels, then loss of lock
        n_sop = 0; max_miss = 0;
        for (int i = 0; i < 400; i++) begin
            do_pulse_chk(1'b0);
            if (!g_lk) break;
            if (g_sop) n_sop++;
            if (int'(g_miss) > max_miss) max_miss = int'(g_miss);
        end
        chk("flywheel count", 32'(n_sop), 32'(MISSMAX));
        chk("flywheel peak miss", 32'(max_miss), 32'(MISSMAX));
        chk("long locked", 32'(g_lk), 32'd0);
        chk("long start", 32'(g_start), 32'd0);
        chk("long err1", 32'(g_err[1]), 32'd1);
        for (int i = 0; i < 3; i++) begin
            do_pulse_chk(1'b0);
            chk("hunt no start", 32'(g_start), 32'd0);
        end
        do_pulse_chk(1'b1);
        chk("relock sop", 32'(g_sop), 32'd1);
        chk("relock frame", 32'(g_frame), 32'd0);
        chk("relock miss", 32'(g_miss), 32'd0);

        // spclk stops: watchdog fires TOUT cycles after the last strobe
        cnt = 0;
        for (int i = 1; i <= 2 * TOUT; i++) begin
            @(posedge clk); #1;
            if (err_o[2]) begin
                cnt = i;
                break;
            end
        end
        chk("timeout cycles", 32'(cnt), 32'(TOUT));
        chk("timeout locked", 32'(locked_o), 32'd0);

        // en falls while a strobe is due
        do_pulse_chk(1'b1);
        chk("lock before en drop", 32'(g_lk), 32'd1);
        @(negedge clk); sync_i = 1'b0;
        repeat (3) @(negedge clk);
        spclk_i = 1'b1;
        repeat (3) @(negedge clk);
        en = 1'b0;
        @(posedge clk); #1;
        chk("en drop outputs", 32'(pack_dut()), 32'd0);
        @(negedge clk); spclk_i = 1'b0; en = 1'b1;
        do_pulse_chk(1'b0);
        chk("after en no start", 32'(g_start), 32'd0);

        // Asynchronous reset in the middle of a pulse
        do_pulse_chk(1'b1);
        chk("lock before reset", 32'(g_lk), 32'd1);
        @(negedge clk); spclk_i = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async reset outputs", 32'(pack_dut()), 32'd0);
        repeat (3) @(negedge clk);
        spclk_i = 1'b0; rst_n = 1'b1;
        do_pulse_chk(1'b0);
        chk("after reset no start", 32'(g_start), 32'd0);
        chk("after reset locked", 32'(g_lk), 32'd0);
        do_pulse_chk(1'b1);
        chk("fresh lock sop", 32'(g_sop), 32'd1);
        chk("fresh lock frame", 32'(g_frame), 32'd0);

        // Randomized traffic: mostly well-formed frames with occasional
        // missing/early sync, enable drops and gaps around the timeout
        ph = 1;
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 999));
            if (r < 6) begin
                @(negedge clk); en = 1'b0;
                repeat (int'($urandom_range(1, 6))) @(negedge clk);
                en = 1'b1;
            end else if (r < 14) begin
                repeat (TOUT - 8 + int'($urandom_range(0, 12))) @(negedge clk);
            end
            if (ph == 0) s = ($urandom_range(0, 99) < 85);
            else         s = ($urandom_range(0, 99) < 2);
            ph = s ? 1 : (ph + 1) % SPF;
            do_pulse(s, int'($urandom_range(3, 7)), int'($urandom_range(3, 7)));
        end
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
